// File: rtl/q_reg_encoder.sv
// q_reg_encoder
//   Packs a 110-qubit operation map into one register write word.
//   Single-qubit mode (sel 01) emits an activity mask, in a 46-bit
//   windowed short form when it fits and a full 110-bit long form
//   otherwise. Two-qubit mode (sel 10) pairs controls and targets in
//   ascending index order and emits either one 7-bit pair or up to seven
//   6-bit pairs with a presence mask.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   in_valid/ready  op map offer / encoder idle
//   q_op_in         per-qubit 2-bit op field, qubit i at [2i+:2]
//   q_reg_sel       01 single-qubit, 10 two-qubit, others illegal
//   reg_idx         base register index
//   res_valid/ready result handshake
//   res_addr        {long_form, reg_idx}
//   res_off         short single-qubit window offset (units of 4 qubits)
//   res_data        register payload
//   res_err         encode failed (payload forced to 0)
//   res_code        0 ok, 1 illegal field/sel, 2 pairing, 3 capacity
//   fsm_state       debug view of the controller state
//
// Handshake: a transfer happens on a rising edge where valid and ready
// are both high. in_ready is high only in IDLE; res_valid is high only in
// EMIT and every res_* output is held until the transfer completes.
module q_reg_encoder (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [219:0] q_op_in,
   input  logic [1:0]   q_reg_sel,
   input  logic [3:0]   reg_idx,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [4:0]   res_addr,
   output logic [4:0]   res_off,
   output logic [109:0] res_data,
   output logic         res_err,
   output logic [1:0]   res_code,
   output logic [1:0]   fsm_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_EMIT = 2'd2
   } state_t;

   localparam logic [109:0] SHORT_MASK = {64'd0, {46{1'b1}}};

   state_t state, state_nxt;

   logic [219:0] op_q;        // latched map, shifted right 2 bits per scan step
   logic [1:0]   sel_q;
   logic [3:0]   ridx_q;
   logic [6:0]   scan_idx;
   logic [109:0] act_q;       // active flags shifted in from the top
   logic         any_act;
   logic [6:0]   lo_q;
   logic [6:0]   hi_q;
   logic         fld_err;
   logic [6:0]   c_cnt;
   logic [6:0]   t_cnt;
   logic         big_q;       // some control/target index above 63
   logic [6:0]   ctl_idx [8];
   logic [6:0]   tgt_idx [8];

   logic         accept;
   logic         sel_ok;
   logic         scan_done;
   logic         single_mode;
   logic [1:0]   fld;
   logic [6:0]   lo_div;
   logic [4:0]   sgl_off;
   logic [6:0]   sgl_base;

   logic         fin_long;
   logic [4:0]   fin_off;
   logic [109:0] fin_data;
   logic [1:0]   fin_code;

   assign in_ready    = (state == S_IDLE);
   assign res_valid   = (state == S_EMIT);
   assign fsm_state   = state;
   assign accept      = in_valid & in_ready;
   assign sel_ok      = (q_reg_sel == 2'b01) || (q_reg_sel == 2'b10);
   // Index 110 is a finalize step: all 110 qubits are accumulated.
   assign scan_done   = (scan_idx == 7'd110);
   assign single_mode = (sel_q == 2'b01);
   assign fld         = op_q[1:0];

   // Window offset is capped at 16 so the 46-bit window never runs past 109.
   assign lo_div   = lo_q >> 2;
   assign sgl_off  = (lo_div > 7'd16) ? 5'd16 : lo_div[4:0];
   assign sgl_base = {sgl_off, 2'b00};

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = sel_ok ? S_SCAN : S_EMIT;
         S_SCAN: if (scan_done) state_nxt = S_EMIT;
         S_EMIT: if (res_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Result formation from the completed accumulators.
   always_comb begin
      fin_long = 1'b0;
      fin_off  = '0;
      fin_data = '0;
      fin_code = 2'd0;
      if (fld_err) begin
         fin_code = 2'd1;
      end else if (single_mode) begin
         if (any_act && ({1'b0, hi_q} > ({1'b0, sgl_base} + 8'd45))) begin
            fin_long = 1'b1;
            fin_data = act_q;
         end else if (any_act) begin
            fin_off  = sgl_off;
            fin_data = (act_q >> sgl_base) & SHORT_MASK;
         end
      end else begin
         if ((c_cnt > 7'd7) || (t_cnt > 7'd7)) begin
            fin_code = 2'd3;
         end else if ((c_cnt != t_cnt) || (c_cnt == 7'd0)) begin
            fin_code = 2'd2;
         end else if (c_cnt == 7'd1) begin
            fin_data[6:0]  = ctl_idx[0];
            fin_data[13:7] = tgt_idx[0];
         end else if (big_q) begin
            // 6-bit pair fields cannot hold indices above 63.
            fin_code = 2'd3;
         end else begin
            fin_long = 1'b1;
            for (int j = 0; j < 7; j++) begin
               if (c_cnt > 7'(j)) begin
                  fin_data[14*j +: 6]   = ctl_idx[j][5:0];
                  fin_data[14*j+7 +: 6] = tgt_idx[j][5:0];
                  fin_data[98+j]        = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q     <= '0;
         sel_q    <= '0;
         ridx_q   <= '0;
         scan_idx <= '0;
         act_q    <= '0;
         any_act  <= 1'b0;
         lo_q     <= '0;
         hi_q     <= '0;
         fld_err  <= 1'b0;
         c_cnt    <= '0;
         t_cnt    <= '0;
         big_q    <= 1'b0;
         for (int j = 0; j < 8; j++) begin
            ctl_idx[j] <= '0;
            tgt_idx[j] <= '0;
         end
         res_addr <= '0;
         res_off  <= '0;
         res_data <= '0;
         res_err  <= 1'b0;
         res_code <= '0;
      end else begin
         if ((state == S_IDLE) && accept) begin
            op_q     <= q_op_in;
            sel_q    <= q_reg_sel;
            ridx_q   <= reg_idx;
            scan_idx <= '0;
            act_q    <= '0;
            any_act  <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
            fld_err  <= 1'b0;
            c_cnt    <= '0;
            t_cnt    <= '0;
            big_q    <= 1'b0;
            if (!sel_ok) begin
               res_addr <= {1'b0, reg_idx};
               res_off  <= '0;
               res_data <= '0;
               res_err  <= 1'b1;
               res_code <= 2'd1;
            end
         end else if ((state == S_SCAN) && !scan_done) begin
            op_q     <= op_q >> 2;
            scan_idx <= scan_idx + 7'd1;
            act_q    <= {single_mode && (fld == 2'b11), act_q[109:1]};
            if (single_mode) begin
               if (fld == 2'b11) begin
                  if (!any_act) lo_q <= scan_idx;
                  hi_q    <= scan_idx;
                  any_act <= 1'b1;
               end else if (fld != 2'b00) begin
                  fld_err <= 1'b1;
               end
            end else begin
               if (fld == 2'b10) begin
                  if (c_cnt < 7'd7) ctl_idx[c_cnt[2:0]] <= scan_idx;
                  c_cnt <= c_cnt + 7'd1;
                  if (scan_idx > 7'd63) big_q <= 1'b1;
               end else if (fld == 2'b01) begin
                  if (t_cnt < 7'd7) tgt_idx[t_cnt[2:0]] <= scan_idx;
                  t_cnt <= t_cnt + 7'd1;
                  if (scan_idx > 7'd63) big_q <= 1'b1;
               end else if (fld == 2'b11) begin
                  fld_err <= 1'b1;
               end
            end
         end else if ((state == S_SCAN) && scan_done) begin
            res_addr <= {fin_long, ridx_q};
            res_off  <= fin_off;
            res_data <= fin_data;
            res_err  <= (fin_code != 2'd0);
            res_code <= fin_code;
         end
      end
   end

endmodule

// File: tb/tb_q_reg_encoder.sv
module tb_q_reg_encoder;

   localparam int W = 123;   // {addr5, off5, data110, err1, code2}

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [219:0] q_op_in = '0;
   logic [1:0]   q_reg_sel = '0;
   logic [3:0]   reg_idx = '0;
   logic         res_valid;
   logic         res_ready = 1'b0;
   logic [4:0]   res_addr;
   logic [4:0]   res_off;
   logic [109:0] res_data;
   logic         res_err;
   logic [1:0]   res_code;
   logic [1:0]   fsm_state;

   q_reg_encoder dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .q_op_in(q_op_in), .q_reg_sel(q_reg_sel), .reg_idx(reg_idx),
      .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr),
      .res_off(res_off), .res_data(res_data), .res_err(res_err),
      .res_code(res_code), .fsm_state(fsm_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int unsigned  cyc_q[$];
   int           n_cmp = 0;
   int           n_bad = 0;
   logic         seen = 1'b0;
   logic         hs_pend = 1'b0;
   logic [W-1:0] snap;
   int           ready_mode = 0;   // 0 random, 1 held low, 2 held high

   function automatic logic [W-1:0] cur_out();
      return {res_addr, res_off, res_data, res_err, res_code};
   endfunction

   function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] model(input logic [219:0] ops, input logic [1:0] sel,
                                          input logic [3:0] ridx);
      logic [4:0]   addr;
      logic [4:0]   off;
      logic [109:0] data;
      logic         err;
      logic [1:0]   code;
      logic [1:0]   f;
      int           act[$];
      int           ctl[$];
      int           tgt[$];
      bit           bad;
      bit           big;
      int           lo, hi, o;
      addr = {1'b0, ridx};
      off  = '0;
      data = '0;
      code = 2'd0;
      bad  = 0;
      big  = 0;
      if (sel != 2'b01 && sel != 2'b10) begin
         code = 2'd1;
      end else begin
         for (int i = 0; i < 110; i++) begin
            f = ops[2*i +: 2];
            if (sel == 2'b01) begin
               if (f == 2'b11) act.push_back(i);
               else if (f != 2'b00) bad = 1;
            end else begin
               if (f == 2'b10) ctl.push_back(i);
               else if (f == 2'b01) tgt.push_back(i);
               else if (f == 2'b11) bad = 1;
            end
         end
         if (bad) begin
            code = 2'd1;
         end else if (sel == 2'b01) begin
            if (act.size() > 0) begin
               lo = act[0];
               hi = act[act.size()-1];
               o  = lo / 4;
               if (o > 16) o = 16;
               if (hi <= 4*o + 45) begin
                  off = 5'(o);
                  foreach (act[k]) data[act[k] - 4*o] = 1'b1;
               end else begin
                  addr[4] = 1'b1;
                  foreach (act[k]) data[act[k]] = 1'b1;
               end
            end
         end else begin
            if (ctl.size() > 7 || tgt.size() > 7) code = 2'd3;
            else if (ctl.size() != tgt.size() || ctl.size() == 0) code = 2'd2;
            else begin
               foreach (ctl[k]) if (ctl[k] > 63 || tgt[k] > 63) big = 1;
               if (ctl.size() >= 2 && big) code = 2'd3;
               else if (ctl.size() == 1) begin
                  data[6:0]  = 7'(ctl[0]);
                  data[13:7] = 7'(tgt[0]);
               end else begin
                  addr[4] = 1'b1;
                  foreach (ctl[j]) begin
                     data[14*j +: 6]   = 6'(ctl[j]);
                     data[14*j+7 +: 6] = 6'(tgt[j]);
                     data[98+j]        = 1'b1;
                  end
               end
            end
         end
      end
      err = (code != 2'd0);
      if (err) begin
         addr = {1'b0, ridx};
         off  = '0;
         data = '0;
      end
      return {addr, off, data, err, code};
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (hs_pend) seen = 1'b0;
      hs_pend = 1'b0;
      if (rst_n && res_valid) begin
         if (!seen) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_result: got %h expected no result", cur_out());
            end else begin
               check("result", cur_out(), exp_q.pop_front());
               check("latency", W'(cyc), W'(cyc_q.pop_front()));
            end
            snap = cur_out();
            seen = 1'b1;
         end else begin
            check("hold", cur_out(), snap);
         end
      end
      case (ready_mode)
         1:       res_ready = 1'b0;
         2:       res_ready = 1'b1;
         default: res_ready = ($urandom_range(0, 3) != 0);
      endcase
      hs_pend = rst_n && res_valid && res_ready;
   end

   // ---------------- driver tasks ----------------
   function automatic logic [219:0] rand220();
      logic [219:0] v;
      v = '0;
      for (int k = 0; k < 7; k++) v = {v[187:0], 32'($urandom)};
      return v;
   endfunction

   task automatic do_reset(input int n);
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      cyc_q.delete();
      seen = 1'b0;
      hs_pend = 1'b0;
      repeat (n) @(negedge clk);
      check("rst_in_ready", W'(in_ready), W'(1));
      check("rst_res_valid", W'(res_valid), W'(0));
      check("rst_outputs", cur_out(), '0);
      rst_n = 1'b1;
   endtask

   task automatic send(input logic [219:0] ops, input logic [1:0] sel,
                       input logic [3:0] ridx, input int garbage);
      int  t;
      bit  legal;
      t = 0;
      legal = (sel == 2'b01 || sel == 2'b10);
      @(negedge clk);
      while (!in_ready && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL in_ready_timeout: got 0 expected 1");
         return;
      end
      in_valid  = 1'b1;
      q_op_in   = ops;
      q_reg_sel = sel;
      reg_idx   = ridx;
      exp_q.push_back(model(ops, sel, ridx));
      cyc_q.push_back(cyc + (legal ? 112 : 1));
      @(negedge clk);
      // Busy-period offers with changing data must be ignored.
      if (legal) begin
         repeat (garbage) begin
            q_op_in   = rand220();
            q_reg_sel = 2'($urandom);
            reg_idx   = 4'($urandom);
            @(negedge clk);
         end
      end
      in_valid = 1'b0;
      q_op_in  = rand220();
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || !in_ready) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: got pending %0d expected 0", exp_q.size());
      end
   endtask

   // ---------------- stimulus generators ----------------
   function automatic logic [219:0] gen_single();
      logic [219:0] ops;
      int r, lo, hi;
      ops = '0;
      r  = $urandom_range(0, 9);
      if (r == 8) return ops;
      lo = $urandom_range(0, 109);
      hi = lo + $urandom_range(0, (r < 6) ? 45 : 109);
      if (hi > 109) hi = 109;
      for (int i = lo; i <= hi; i++)
         if (i == lo || i == hi || $urandom_range(0, 2) != 0) ops[2*i +: 2] = 2'b11;
      if (r == 9) ops[2*$urandom_range(0, 109) +: 2] = 2'($urandom_range(1, 2));
      return ops;
   endfunction

   function automatic logic [219:0] gen_double();
      logic [219:0] ops;
      int n, nc, nt, maxi, idx;
      ops  = '0;
      n    = $urandom_range(0, 8);
      maxi = ($urandom_range(0, 1) != 0) ? 63 : 109;
      nc   = n;
      nt   = n;
      if ($urandom_range(0, 4) == 0) nc = nc + 1;
      for (int k = 0; k < nc + nt; k++) begin
         for (int tries = 0; tries < 200; tries++) begin
            idx = $urandom_range(0, maxi);
            if (ops[2*idx +: 2] == 2'b00) begin
               ops[2*idx +: 2] = (k < nc) ? 2'b10 : 2'b01;
               break;
            end
         end
      end
      if ($urandom_range(0, 9) == 0) ops[2*$urandom_range(0, 109) +: 2] = 2'b11;
      return ops;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      logic [219:0] ops;
      int t;
      do_reset(3);

      // Single: qubits 8..50 active -> off 2, short, 43 ones
      ops = '0;
      for (int i = 8; i <= 50; i++) ops[2*i +: 2] = 2'b11;
      send(ops, 2'b01, 4'd3, 5);
      // Single: qubits 3 and 100 -> long
      ops = '0; ops[2*3 +: 2] = 2'b11; ops[2*100 +: 2] = 2'b11;
      send(ops, 2'b01, 4'd9, 0);
      // Double: one pair (5,90) -> short
      ops = '0; ops[2*5 +: 2] = 2'b10; ops[2*90 +: 2] = 2'b01;
      send(ops, 2'b10, 4'd1, 0);
      // Double: (0,1),(2,3),(4,70) -> capacity
      ops = '0;
      ops[0 +: 2] = 2'b10; ops[2 +: 2] = 2'b01; ops[4 +: 2] = 2'b10; ops[6 +: 2] = 2'b01;
      ops[8 +: 2] = 2'b10; ops[2*70 +: 2] = 2'b01;
      send(ops, 2'b10, 4'd2, 0);
      // Same with target 63 -> long with 3-bit mask
      ops[2*70 +: 2] = 2'b00; ops[2*63 +: 2] = 2'b01;
      send(ops, 2'b10, 4'd2, 0);
      // Two controls, one target -> pairing
      ops = '0; ops[2*10 +: 2] = 2'b10; ops[2*20 +: 2] = 2'b10; ops[2*30 +: 2] = 2'b01;
      send(ops, 2'b10, 4'd4, 0);
      // Single with an illegal 01 field
      ops = '0; ops[2*7 +: 2] = 2'b01;
      send(ops, 2'b01, 4'd5, 0);
      // Illegal selects
      send(rand220(), 2'b00, 4'd6, 0);
      send(rand220(), 2'b11, 4'd7, 0);
      // Single, nothing active
      send('0, 2'b01, 4'd8, 0);
      // Window boundary: hi = base+45 (short) and base+46 (long)
      ops = '0; ops[2*40 +: 2] = 2'b11; ops[2*85 +: 2] = 2'b11;
      send(ops, 2'b01, 4'd10, 0);
      ops[2*85 +: 2] = 2'b00; ops[2*86 +: 2] = 2'b11;
      send(ops, 2'b01, 4'd11, 0);
      // Offset cap at 16
      ops = '0; ops[2*100 +: 2] = 2'b11; ops[2*109 +: 2] = 2'b11;
      send(ops, 2'b01, 4'd12, 0);
      // Eight pairs -> capacity; seven pairs -> long, full mask
      ops = '0;
      for (int k = 0; k < 8; k++) begin
         ops[2*(2*k) +: 2] = 2'b10;
         ops[2*(2*k+1) +: 2] = 2'b01;
      end
      send(ops, 2'b10, 4'd13, 0);
      ops[2*14 +: 2] = 2'b00; ops[2*15 +: 2] = 2'b00;
      send(ops, 2'b10, 4'd14, 0);

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 9))
            0:       send(rand220(), ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11, 4'($urandom), 0);
            1, 2, 3, 4: send(gen_single(), 2'b01, 4'($urandom), $urandom_range(0, 20));
            default: send(gen_double(), 2'b10, 4'($urandom), $urandom_range(0, 20));
         endcase
      end
      drain();

      // Backpressure: result held for 10 cycles, then released
      ready_mode = 1;
      ops = '0; ops[2*20 +: 2] = 2'b11; ops[2*30 +: 2] = 2'b11;
      send(ops, 2'b01, 4'd15, 0);
      t = 0;
      while (!res_valid && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("emit_reached", W'(res_valid), W'(1));
      repeat (10) @(negedge clk);
      ready_mode = 2;
      drain();
      ready_mode = 0;

      // Reset during SCAN abandons the operation
      send(gen_single(), 2'b01, 4'd2, 0);
      repeat (20) @(negedge clk);
      check("mid_scan_busy", W'(in_ready), W'(0));
      do_reset(1);
      t = 0;
      for (int k = 0; k < 150; k++) begin
         @(negedge clk);
         if (res_valid) t++;
      end
      check("abandoned_no_valid", W'(t), W'(0));
      check("abandoned_in_ready", W'(in_ready), W'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/q_reg_encoder.md
Q_REG_ENCODER -- requirements
Module: q_reg_encoder

Interface
REQ-001 Parameters: none; fixed geometry of 110 qubits, 2-bit op field per qubit, up to 7 pairs in the long two-qubit format.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 in_valid  in  1  op map offered.
REQ-005 in_ready  out  1  encoder idle, can accept.
REQ-006 q_op_in  in  220  per-qubit op map; qubit i at [2i+:2].
REQ-007 q_reg_sel  in  2  01 single-qubit, 10 two-qubit; others illegal.
REQ-008 reg_idx  in  4  base register index.
REQ-009 res_valid  out  1  result word valid.
REQ-010 res_ready  in  1  consumer accepts result.
REQ-011 res_addr  out  5  bit4 = long format, [3:0] = captured reg_idx.
REQ-012 res_off  out  5  short single-qubit window offset.
REQ-013 res_data  out  110  register payload.
REQ-014 res_err  out  1  encode failed; res_data = 0.
REQ-015 res_code  out  2  0 ok, 1 illegal field or sel, 2 pairing, 3 capacity.

Function
REQ-016 FSM states: IDLE, SCAN, EMIT; in_ready = 1 only in IDLE.
REQ-017 Acceptance: in_valid & in_ready on an edge latches q_op_in, q_reg_sel, reg_idx; the state moves to SCAN with scan index 0.
REQ-018 Illegal sel: on acceptance, go directly to EMIT with res_err = 1, code 1; res_valid is high on the next cycle.
REQ-019 SCAN: one qubit per cycle, index 0..109; after index 109, enter EMIT; res_valid rises 111 cycles after the acceptance edge.
REQ-020 Single mode field values: 11 = active, 00 = idle, 01/10 = code 1.
REQ-021 Single mode tracking: lo/hi = lowest/highest active index.
REQ-022 Single mode window: off = min(floor(lo/4), 16).
REQ-023 Single short form (res_addr[4] = 0): used if no qubit is active, with off = 0 and data = 0; also used if hi <= 4*off + 45, with res_data[k] = active(4*off + k) for k < 46 and bits [109:46] = 0.
REQ-024 Single long form (res_addr[4] = 1) otherwise: res_data[i] = active(i); res_off = 0.
REQ-025 Double mode field values: 10 = control, 01 = target, 00 = idle, 11 = code 1.
REQ-026 Double mode collection: controls and targets are queued separately in ascending index; pair k is control k with target k.
REQ-027 Double mode pairing errors: control count != target count, or zero pairs, gives code 2.
REQ-028 Double mode capacity errors: more than 7 pairs gives code 3; 2..7 pairs with any index > 63 also gives code 3.
REQ-029 Double short form (exactly 1 pair): res_data[6:0] = control index and [13:7] = target index; other bits and res_off are 0.
REQ-030 Double long form (2..7 pairs), pair j < n: [14j+:6] = control index, [14j+7+:6] = target index, [98+j] = 1.
REQ-031 Double long form, other bits: all remaining bits are 0, including [14j+6], [14j+13] and unused pairs.
REQ-032 Error precedence: code 1 > code 3 > code 2; scanning continues to index 109 after an error is found.
REQ-033 EMIT: res_* outputs are held stable while res_valid & !res_ready.
REQ-034 EMIT exit: on the res handshake, go to IDLE; in_ready is high the next cycle, with no same-cycle re-accept.
REQ-035 in_valid is ignored outside IDLE; later q_op_in changes do not affect the latched copy.
REQ-036 Round trip: every ok result fed to the matching decoder (same sel, addr bit4, off) reproduces the original q_op_in.

Reset
REQ-037 rst_n = 0 at an edge: state IDLE, res_valid = 0, res_err = 0, res_code = 0, res_addr/res_off/res_data = 0, in_ready = 1 after the edge.
REQ-038 Reset mid-SCAN or mid-EMIT abandons the operation; no result is emitted.

Verification
REQ-039 Single, qubits 8..50 = 11: off = 2, short, res_data[k] = 1 for k = 0..42; res_valid at acceptance + 111.
REQ-040 Single, qubits 3 and 100 = 11: long, res_data[3] = res_data[100] = 1, addr bit4 = 1.
REQ-041 Double, q5 = 10, q90 = 01: short, res_data[6:0] = 5, [13:7] = 90.
REQ-042 Double, pairs (0,1),(2,3),(4,70): code 3; same with (4,63): long, mask [100:98] = 111.
REQ-043 Double, two controls and one target: code 2; single with q7 = 01: code 1.
REQ-044 res_ready low 10 cycles in EMIT: outputs stable; then reset asserted during the next SCAN: no res_valid, in_ready = 1.
